// File: rtl/pipeline_control_pkg.sv
// Shared types for the ID->EX->MA->WB pipeline control slice.
package pipeline_control_pkg;

    // Architectural register index x0..x31.
    typedef logic [4:0] rv32_register;

    // Memory operation carried by an instruction; memop_none encodes as zero
    // so a cleared register naturally reads as "no memory access".
    typedef enum logic [3:0] {
        memop_none = 4'd0,
        memop_lb   = 4'd1,
        memop_lh   = 4'd2,
        memop_lw   = 4'd3,
        memop_lbu  = 4'd4,
        memop_lhu  = 4'd5,
        memop_sb   = 4'd6,
        memop_sh   = 4'd7,
        memop_sw   = 4'd8
    } rv32_memop;

    // Decoded per-cycle pipeline action, highest priority last.
    typedef enum logic [1:0] {
        PC_NORMAL    = 2'd0,
        PC_LOAD_USE  = 2'd1,
        PC_BRANCH    = 2'd2,
        PC_MEM_STALL = 2'd3
    } pipe_ctrl_e;

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Advance on request unless already saturated.
    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Stage tracking and stall/flush/bubble control for the EX, MA and WB stages.
// Also feeds the bypass unit with per-stage rd/memop/valid.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  rv32_register      i_id_rd,
    input  logic              i_id_we,
    input  rv32_memop         i_id_memop,
    input  logic              i_hazard,
    input  logic              i_branch_taken,
    input  logic              i_mem_busy,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_flush_id,
    output rv32_register      o_rd_ex,
    output rv32_register      o_rd_ma,
    output rv32_register      o_rd_wb,
    output rv32_memop         o_ex_memop,
    output rv32_memop         o_ma_memop,
    output logic              o_valid_ex,
    output logic              o_valid_ma,
    output logic              o_valid_wb,
    output logic              o_rf_we,
    output logic [CNT_W-1:0]  o_stall_cycles,
    output logic [CNT_W-1:0]  o_flush_count
);

    pipe_ctrl_e   action;

    logic         ex_valid_d, ex_valid_q;
    logic         ex_we_d,    ex_we_q;
    rv32_register ex_rd_d,    ex_rd_q;
    rv32_memop    ex_memop_d, ex_memop_q;

    logic         ma_valid_d, ma_valid_q;
    logic         ma_we_d,    ma_we_q;
    rv32_register ma_rd_d,    ma_rd_q;
    rv32_memop    ma_memop_d, ma_memop_q;

    logic         wb_valid_d, wb_valid_q;
    logic         wb_we_d,    wb_we_q;
    rv32_register wb_rd_d,    wb_rd_q;

    logic         stall_any;
    logic         flush_any;

    // Pick this cycle's action: memory busy beats a branch in EX, which beats
    // load-use (the ID instruction is wrong-path once a redirect fires).
    // While reset is held nothing is stalled or flushed.
    always_comb begin
        action = PC_NORMAL;
        if (i_rst) begin
            action = PC_NORMAL;
        end else if (i_mem_busy) begin
            action = PC_MEM_STALL;
        end else if (ex_valid_q && i_branch_taken) begin
            action = PC_BRANCH;
        end else if (i_hazard && i_id_valid) begin
            action = PC_LOAD_USE;
        end
    end

    // Next-state for the three stages according to the chosen action.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_we_d    = ex_we_q;
        ex_rd_d    = ex_rd_q;
        ex_memop_d = ex_memop_q;
        ma_valid_d = ma_valid_q;
        ma_we_d    = ma_we_q;
        ma_rd_d    = ma_rd_q;
        ma_memop_d = ma_memop_q;
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;

        case (action)
            PC_MEM_STALL: begin
                // EX and MA hold; WB retires and is refilled with a bubble.
                wb_valid_d = 1'b0;
                wb_we_d    = 1'b0;
            end
            PC_BRANCH, PC_LOAD_USE: begin
                // Bubble into EX (stale rd is harmless, valid gates it).
                ex_valid_d = 1'b0;
                ex_we_d    = 1'b0;
                ex_memop_d = memop_none;
                ma_valid_d = ex_valid_q;
                ma_we_d    = ex_we_q;
                ma_rd_d    = ex_rd_q;
                ma_memop_d = ex_memop_q;
                wb_valid_d = ma_valid_q;
                wb_we_d    = ma_we_q;
                wb_rd_d    = ma_rd_q;
            end
            default: begin
                ex_valid_d = i_id_valid;
                ex_we_d    = i_id_valid & i_id_we;
                ex_rd_d    = i_id_rd;
                ex_memop_d = i_id_valid ? i_id_memop : memop_none;
                ma_valid_d = ex_valid_q;
                ma_we_d    = ex_we_q;
                ma_rd_d    = ex_rd_q;
                ma_memop_d = ex_memop_q;
                wb_valid_d = ma_valid_q;
                wb_we_d    = ma_we_q;
                wb_rd_d    = ma_rd_q;
            end
        endcase
    end

    // Stage registers, cleared asynchronously to empty stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_rd_q    <= '0;
            ex_memop_q <= memop_none;
            ma_valid_q <= 1'b0;
            ma_we_q    <= 1'b0;
            ma_rd_q    <= '0;
            ma_memop_q <= memop_none;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_we_q    <= ex_we_d;
            ex_rd_q    <= ex_rd_d;
            ex_memop_q <= ex_memop_d;
            ma_valid_q <= ma_valid_d;
            ma_we_q    <= ma_we_d;
            ma_rd_q    <= ma_rd_d;
            ma_memop_q <= ma_memop_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign stall_any = (action == PC_MEM_STALL) || (action == PC_LOAD_USE);
    assign flush_any = (action == PC_BRANCH);

    assign o_stall_if = stall_any;
    assign o_stall_id = stall_any;
    assign o_flush_id = flush_any;

    assign o_rd_ex    = ex_rd_q;
    assign o_rd_ma    = ma_rd_q;
    assign o_rd_wb    = wb_rd_q;
    assign o_ex_memop = ex_memop_q;
    assign o_ma_memop = ma_memop_q;

    // Bypass consumers only care about stages that will write a register.
    assign o_valid_ex = ex_valid_q & ex_we_q;
    assign o_valid_ma = ma_valid_q & ma_we_q;
    assign o_valid_wb = wb_valid_q & wb_we_q;
    assign o_rf_we    = wb_valid_q & wb_we_q & (wb_rd_q != '0);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (stall_any),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (flush_any),
        .o_count (o_flush_count)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed, table-driven bench for pipeline_control (CNT_W = 4).
module tb_pipeline_control;
    import pipeline_control_pkg::*;

    localparam int CW = 4;

    logic              clk;
    logic              rst;
    logic              id_valid;
    rv32_register      id_rd;
    logic              id_we;
    rv32_memop         id_memop;
    logic              hazard;
    logic              branch_taken;
    logic              mem_busy;
    logic              stall_if, stall_id, flush_id;
    rv32_register      rd_ex, rd_ma, rd_wb;
    rv32_memop         ex_memop, ma_memop;
    logic              valid_ex, valid_ma, valid_wb, rf_we;
    logic [CW-1:0]     stall_cycles, flush_count;

    pipeline_control #(.CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_rd        (id_rd),
        .i_id_we        (id_we),
        .i_id_memop     (id_memop),
        .i_hazard       (hazard),
        .i_branch_taken (branch_taken),
        .i_mem_busy     (mem_busy),
        .o_stall_if     (stall_if),
        .o_stall_id     (stall_id),
        .o_flush_id     (flush_id),
        .o_rd_ex        (rd_ex),
        .o_rd_ma        (rd_ma),
        .o_rd_wb        (rd_wb),
        .o_ex_memop     (ex_memop),
        .o_ma_memop     (ma_memop),
        .o_valid_ex     (valid_ex),
        .o_valid_ma     (valid_ma),
        .o_valid_wb     (valid_wb),
        .o_rf_we        (rf_we),
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         idv;
        logic [4:0]   rd;
        logic         we;
        rv32_memop    mop;
        logic         hz;
        logic         br;
        logic         busy;
        logic         e_sif;
        logic         e_sid;
        logic         e_fl;
        logic         e_vex;
        logic [4:0]   e_rex;
        rv32_memop    e_mex;
        logic         e_vma;
        logic [4:0]   e_rma;
        rv32_memop    e_mma;
        logic         e_vwb;
        logic [4:0]   e_rwb;
        logic         e_rfwe;
        logic [3:0]   e_sc;
        logic [3:0]   e_fc;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    int    n_total;
    int    n_pass;
    string tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_all_zero();
        chk("stall_if", stall_if, 0);
        chk("stall_id", stall_id, 0);
        chk("flush_id", flush_id, 0);
        chk("rd_ex", rd_ex, 0);
        chk("rd_ma", rd_ma, 0);
        chk("rd_wb", rd_wb, 0);
        chk("ex_memop", ex_memop, memop_none);
        chk("ma_memop", ma_memop, memop_none);
        chk("valid_ex", valid_ex, 0);
        chk("valid_ma", valid_ma, 0);
        chk("valid_wb", valid_wb, 0);
        chk("rf_we", rf_we, 0);
        chk("stall_cycles", stall_cycles, 0);
        chk("flush_count", flush_count, 0);
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic w, input rv32_memop m,
                         input logic h, input logic b, input logic bz);
        id_valid     = v;
        id_rd        = r;
        id_we        = w;
        id_memop     = m;
        hazard       = h;
        branch_taken = b;
        mem_busy     = bz;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        tag     = "reset";

        // idv rd we mop hz br busy | sif sid fl | vex rex mex | vma rma mma | vwb rwb rfwe | sc fc
        vt[0]  = '{1,1,1,memop_none,0,0,0, 0,0,0, 0,0,memop_none,  0,0,memop_none,  0,0,0,  0,0};
        vt[1]  = '{1,2,1,memop_none,0,0,0, 0,0,0, 1,1,memop_none,  0,0,memop_none,  0,0,0,  0,0};
        vt[2]  = '{1,3,1,memop_none,0,0,0, 0,0,0, 1,2,memop_none,  1,1,memop_none,  0,0,0,  0,0};
        vt[3]  = '{0,0,0,memop_none,0,0,0, 0,0,0, 1,3,memop_none,  1,2,memop_none,  1,1,1,  0,0};
        vt[4]  = '{1,5,1,memop_lw,  0,0,0, 0,0,0, 0,0,memop_none,  1,3,memop_none,  1,2,1,  0,0};
        vt[5]  = '{1,6,1,memop_none,1,0,0, 1,1,0, 1,5,memop_lw,    0,0,memop_none,  1,3,1,  0,0};
        vt[6]  = '{1,6,1,memop_none,0,0,0, 0,0,0, 0,5,memop_none,  1,5,memop_lw,    0,0,0,  1,0};
        vt[7]  = '{1,0,0,memop_none,0,0,0, 0,0,0, 1,6,memop_none,  0,5,memop_none,  1,5,1,  1,0};
        vt[8]  = '{1,9,1,memop_none,1,1,0, 0,0,1, 0,0,memop_none,  1,6,memop_none,  0,5,0,  1,0};
        vt[9]  = '{1,4,1,memop_none,0,0,0, 0,0,0, 0,0,memop_none,  0,0,memop_none,  1,6,1,  1,1};
        vt[10] = '{1,7,1,memop_lw,  0,0,0, 0,0,0, 1,4,memop_none,  0,0,memop_none,  0,0,0,  1,1};
        vt[11] = '{1,10,1,memop_none,0,0,0, 0,0,0, 1,7,memop_lw,   1,4,memop_none,  0,0,0,  1,1};
        vt[12] = '{1,11,1,memop_none,0,0,1, 1,1,0, 1,10,memop_none, 1,7,memop_lw,   1,4,1,  1,1};
        vt[13] = '{1,11,1,memop_none,0,0,1, 1,1,0, 1,10,memop_none, 1,7,memop_lw,   0,4,0,  2,1};
        vt[14] = '{1,11,1,memop_none,0,0,1, 1,1,0, 1,10,memop_none, 1,7,memop_lw,   0,4,0,  3,1};
        vt[15] = '{1,11,1,memop_none,0,0,0, 0,0,0, 1,10,memop_none, 1,7,memop_lw,   0,4,0,  4,1};
        vt[16] = '{1,0,1,memop_none,0,0,0, 0,0,0, 1,11,memop_none, 1,10,memop_none, 1,7,1,  4,1};
        vt[17] = '{0,0,0,memop_none,0,0,0, 0,0,0, 1,0,memop_none,  1,11,memop_none, 1,10,1, 4,1};
        vt[18] = '{0,0,0,memop_none,0,0,0, 0,0,0, 0,0,memop_none,  1,0,memop_none,  1,11,1, 4,1};
        vt[19] = '{0,0,0,memop_none,0,0,0, 0,0,0, 0,0,memop_none,  0,0,memop_none,  1,0,0,  4,1};
        vt[20] = '{1,0,0,memop_none,0,0,0, 0,0,0, 0,0,memop_none,  0,0,memop_none,  0,0,0,  4,1};
        vt[21] = '{0,0,0,memop_none,0,1,1, 1,1,0, 0,0,memop_none,  0,0,memop_none,  0,0,0,  4,1};
        vt[22] = '{0,0,0,memop_none,0,1,0, 0,0,1, 0,0,memop_none,  0,0,memop_none,  0,0,0,  5,1};
        vt[23] = '{0,0,0,memop_none,0,0,0, 0,0,0, 0,0,memop_none,  0,0,memop_none,  0,0,0,  5,2};

        // Reset state with noisy inputs held.
        rst = 1'b1;
        drive(1, 5'd9, 1, memop_lw, 1, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, memop_none, 0, 0, 0);
        #1;
        check_all_zero();
        rst = 1'b0;

        // Table-driven sequence: inputs driven at negedge, checked 1 time unit later.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].idv, vt[i].rd, vt[i].we, vt[i].mop, vt[i].hz, vt[i].br, vt[i].busy);
            #1;
            tag = $sformatf("row%0d", i);
            chk("stall_if", stall_if, vt[i].e_sif);
            chk("stall_id", stall_id, vt[i].e_sid);
            chk("flush_id", flush_id, vt[i].e_fl);
            chk("valid_ex", valid_ex, vt[i].e_vex);
            chk("rd_ex", rd_ex, vt[i].e_rex);
            chk("ex_memop", ex_memop, vt[i].e_mex);
            chk("valid_ma", valid_ma, vt[i].e_vma);
            chk("rd_ma", rd_ma, vt[i].e_rma);
            chk("ma_memop", ma_memop, vt[i].e_mma);
            chk("valid_wb", valid_wb, vt[i].e_vwb);
            chk("rd_wb", rd_wb, vt[i].e_rwb);
            chk("rf_we", rf_we, vt[i].e_rfwe);
            chk("stall_cycles", stall_cycles, vt[i].e_sc);
            chk("flush_count", flush_count, vt[i].e_fc);
        end

        // Saturation: stall counter starts at 5, 16 more stall cycles pin it at 4'hF.
        tag = "saturate";
        @(negedge clk);
        drive(0, 0, 0, memop_none, 0, 0, 1);
        repeat (16) @(posedge clk);
        @(negedge clk);
        #1;
        chk("stall_cycles", stall_cycles, 4'hF);
        chk("stall_if", stall_if, 1);
        @(posedge clk);
        #1;
        chk("stall_cycles_hold", stall_cycles, 4'hF);
        chk("flush_count", flush_count, 2);

        // Asynchronous reset in the middle of a stall, away from any clock edge.
        tag = "midstall_rst";
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero();

        // First cycle after release behaves as NORMAL from empty stages.
        tag = "post_rst";
        @(negedge clk);
        rst = 1'b0;
        drive(1, 5'd12, 1, memop_none, 0, 0, 0);
        #1;
        chk("stall_if", stall_if, 0);
        chk("valid_ex", valid_ex, 0);
        @(posedge clk);
        #1;
        chk("valid_ex", valid_ex, 1);
        chk("rd_ex", rd_ex, 12);
        chk("stall_cycles", stall_cycles, 0);
        chk("flush_count", flush_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
